alu_result_buffer: RTL
======================

Name: alu_result_buffer

Overview:
- Stage directly downstream of the 16-bit ALU.
- Captures each ALU result Z and its flags {S, ZR, CY, P, V} through a valid/ready handshake.
- Queues captured entries in a small FIFO for the consumer (register writeback or branch unit).
- Keeps sticky carry/overflow status and a saturating overflow-event counter for software inspection.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNTW, 8, width of the overflow-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  ALU result present.
- in_ready  output  1  buffer can accept an entry this cycle.
- in_Z  input  16  ALU result.
- in_flags  input  5  {S, ZR, CY, P, V}; bit 4 = S, bit 0 = V.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes the head entry.
- out_Z  output  16  head result.
- out_flags  output  5  head flags, same order as in_flags.
- count  output  $clog2(DEPTH)+1  current occupancy.
- clr_sticky  input  1  one-cycle pulse; clears sticky_CY, sticky_V and v_count.
- sticky_CY  output  1  OR of CY over all accepted entries since last clear.
- sticky_V  output  1  OR of V over all accepted entries since last clear.
- v_count  output  CNTW  number of accepted entries with V=1; saturates at all-ones.

Behaviour:
- All state updates on the rising clk edge. rst is sampled synchronously and overrides every other input.
- Reset values:
  - count=0, out_valid=0, in_ready=1.
  - Read and write pointers = 0.
  - sticky_CY=0, sticky_V=0, v_count=0.
  - out_Z and out_flags = 0.
  - Memory contents are not reset.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_Z and out_flags = mem[rd_ptr], meaningful only while out_valid=1.
- Latency: an entry pushed in cycle n is visible on the outputs in cycle n+1 at the earliest. There is no same-cycle bypass.
- Pointers wrap modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored, even if a pop occurs in the same cycle. The freed slot becomes available the next cycle.
- Empty (count=0): out_ready is ignored and pointers hold.
- Data path: each entry stores in_Z and in_flags unmodified. The block never recomputes flags.
- Sticky logic (evaluated on push only):
  - sticky_CY_next = (clr_sticky ? 0 : sticky_CY) | (push & in_flags[2]).
  - sticky_V_next = (clr_sticky ? 0 : sticky_V) | (push & in_flags[0]).
  - When clr_sticky and a flagged push occur in the same cycle, the new event wins.
- v_count:
  - base = clr_sticky ? 0 : v_count.
  - If push & in_flags[0]: base+1, saturating at 2^CNTW-1.
  - Otherwise: base.
- Reset asserted mid-stream discards all queued entries. No pop is reported for them.
- There is no state machine beyond the occupancy count. The FIFO control is the sequential core.

Decomposition:
- Shared package alu_pkg holds:
  - Flag bit-index constants: FLG_S=4, FLG_ZR=3, FLG_CY=2, FLG_P=1, FLG_V=0.
  - ALU data width constant DW=16.
- One natural sub-module, sync_fifo: a generic width/depth FIFO with the push/pop/count rules above, instantiated with width DW+5.
- Sticky and counter logic stays in alu_result_buffer.

Test Plan:
- Reset, then push in_Z=0fff, in_flags=00101 (CY=1, V=1) -> next cycle out_valid=1, out_Z=0fff, out_flags=00101, count=1, sticky_CY=1, sticky_V=1, v_count=1.
- Push 4 entries with out_ready=0: 0000/01100, 5555/00010, 1234/00000, ffff/10010 -> count=4, in_ready=0. A fifth push of aaaa is ignored. Draining with out_ready=1 returns the 4 entries in order, and aaaa never appears.
- Hold full, assert in_valid with value 7777 and out_ready together -> the pop occurs, the push is refused that cycle, and count=3. Next cycle the push is accepted and count=4.
- At count=2, push and pop in the same cycle for 10 cycles -> count stays 2, pointers wrap, and output order is preserved.
- Set v_count to 255 using CNTW=8 and 256 pushes with V=1 -> the 256th push holds 255. Then pulse clr_sticky together with a V=1 push -> v_count=1, sticky_V=1, sticky_CY=0.
- Assert rst with count=3 -> next cycle count=0, out_valid=0, in_ready=1, and all sticky and counter outputs are 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result path: data width, flag bit
// positions and the packed layout of one buffered result entry.
package alu_pkg;

    localparam int DW     = 16;
    localparam int NFLAGS = 5;

    localparam int FLG_S  = 4;
    localparam int FLG_ZR = 3;
    localparam int FLG_CY = 2;
    localparam int FLG_P  = 1;
    localparam int FLG_V  = 0;

    typedef struct packed {
        logic [DW-1:0]     z;
        logic [NFLAGS-1:0] flags;
    } alu_entry_t;

    localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count; ready/valid on
// both sides derive only from registered state, so there is no bypass path.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign push_ready = (count_q != FULL_CNT);
    assign pop_valid  = (count_q != '0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign count      = count_q;

    // Empty head reads as zero so the outputs are defined right after reset.
    assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results and flags for the downstream consumer and keeps sticky
// carry/overflow status plus a saturating overflow-event counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_Z,
    input  logic [NFLAGS-1:0]        in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_Z,
    output logic [NFLAGS-1:0]        out_flags,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_sticky,
    output logic                     sticky_CY,
    output logic                     sticky_V,
    output logic [CNTW-1:0]          v_count
);

    alu_entry_t       wr_entry, rd_entry;
    logic             push;
    logic             sticky_cy_q, sticky_cy_d;
    logic             sticky_v_q, sticky_v_d;
    logic [CNTW-1:0]  v_count_q, v_count_d;
    logic [CNTW-1:0]  v_base;

    assign wr_entry.z     = in_Z;
    assign wr_entry.flags = in_flags;
    assign push           = in_valid & in_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (wr_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (rd_entry),
        .count      (count)
    );

    assign out_Z     = rd_entry.z;
    assign out_flags = rd_entry.flags;

    // A clear and a flagged push in the same cycle leave the new event set.
    always_comb begin
        sticky_cy_d = (clr_sticky ? 1'b0 : sticky_cy_q) | (push & in_flags[FLG_CY]);
        sticky_v_d  = (clr_sticky ? 1'b0 : sticky_v_q)  | (push & in_flags[FLG_V]);
        v_base      = clr_sticky ? '0 : v_count_q;
        v_count_d   = v_base;
        if (push && in_flags[FLG_V] && (v_base != '1)) begin
            v_count_d = v_base + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_cy_q <= 1'b0;
            sticky_v_q  <= 1'b0;
            v_count_q   <= '0;
        end else begin
            sticky_cy_q <= sticky_cy_d;
            sticky_v_q  <= sticky_v_d;
            v_count_q   <= v_count_d;
        end
    end

    assign sticky_CY = sticky_cy_q;
    assign sticky_V  = sticky_v_q;
    assign v_count   = v_count_q;

endmodule
